// File: rtl/usb_ep_status_pkg.sv
// rtl/usb_ep_status_pkg.sv - shared encodings and widths for the EP status aux-port initiator
package usb_ep_status_pkg;

  localparam int ADDR_W     = 9;
  localparam int DATA_W     = 16;
  localparam int LEN_W      = 10;
  localparam int CNT_W      = 4;
  localparam int RD_LAT_DEF = 3;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_REQ  = 3'd1;
  localparam logic [2:0] ST_WAIT = 3'd2;
  localparam logic [2:0] ST_ACK  = 3'd3;
  localparam logic [2:0] ST_CLR  = 3'd4;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } bus_req_t;

endpackage

// File: rtl/usb_ep_status_bus.sv
// rtl/usb_ep_status_bus.sv - bus-side initiator for the EP status RAM aux port
// Single-word register accesses plus a bulk-clear sequencer for USB bus reset.
module usb_ep_status_bus
  import usb_ep_status_pkg::*;
#(
  parameter int RD_LAT = RD_LAT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] bus_addr,
  input  logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_we,
  input  logic              bus_cyc,
  output logic              bus_ack,
  output logic [DATA_W-1:0] bus_rdata,
  input  logic              clr_start,
  input  logic [ADDR_W-1:0] clr_base,
  input  logic [LEN_W-1:0]  clr_len,
  output logic              clr_busy,
  output logic [ADDR_W-1:0] s_addr_0,
  output logic              s_read_0,
  output logic              s_zero_0,
  output logic              s_write_0,
  output logic [DATA_W-1:0] s_din_0,
  input  logic [DATA_W-1:0] s_dout_3,
  input  logic              s_ready_0
);

  logic [1:0]        r_rst_sync;
  logic              w_run;
  logic [2:0]        r_state;
  bus_req_t          r_req;
  logic [CNT_W-1:0]  r_cnt;
  logic [ADDR_W-1:0] r_ptr;
  logic [LEN_W-1:0]  r_rem;
  logic [DATA_W-1:0] r_rdata;

  // Reset asserts asynchronously; release is held off two clocks
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rst_sync <= 2'b00;
    else        r_rst_sync <= {r_rst_sync[0], 1'b1};
  end

  assign w_run = r_rst_sync[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_req   <= '0;
      r_cnt   <= '0;
      r_ptr   <= '0;
      r_rem   <= '0;
      r_rdata <= '0;
    end else if (w_run) begin
      case (r_state)
        ST_IDLE: begin
          // A clear takes precedence; a concurrent bus_cyc stays pending
          if (clr_start && (clr_len != '0)) begin
            r_ptr   <= clr_base;
            r_rem   <= clr_len;
            r_state <= ST_CLR;
          end else if (bus_cyc) begin
            r_req.we    <= bus_we;
            r_req.addr  <= bus_addr;
            r_req.wdata <= bus_wdata;
            r_state     <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (s_ready_0) begin
            if (r_req.we) begin
              r_state <= ST_ACK;
            end else begin
              r_cnt   <= CNT_W'(RD_LAT - 1);
              r_state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (r_cnt == '0) begin
            r_rdata <= s_dout_3;
            r_state <= ST_ACK;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_ACK: begin
          r_state <= ST_IDLE;
        end
        ST_CLR: begin
          if (s_ready_0) begin
            r_ptr <= r_ptr + 1'b1;
            r_rem <= r_rem - 1'b1;
            if (r_rem == LEN_W'(1)) r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus_ack   = (r_state == ST_ACK);
  assign bus_rdata = r_rdata;
  assign clr_busy  = (r_state == ST_CLR);
  assign s_zero_0  = 1'b0;
  assign s_read_0  = (r_state == ST_REQ) && !r_req.we;
  assign s_write_0 = ((r_state == ST_REQ) && r_req.we) || (r_state == ST_CLR);
  assign s_addr_0  = (r_state == ST_CLR) ? r_ptr :
                     (r_state == ST_REQ) ? r_req.addr : '0;
  assign s_din_0   = ((r_state == ST_REQ) && r_req.we) ? r_req.wdata : '0;

endmodule

// File: tb/tb_usb_ep_status_bus.sv
// tb/tb_usb_ep_status_bus.sv - scoreboard bench for usb_ep_status_bus with a 3-stage RAM model
module tb_usb_ep_status_bus;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [8:0]  bus_addr = '0;
  logic [15:0] bus_wdata = '0;
  logic        bus_we = 1'b0;
  logic        bus_cyc = 1'b0;
  logic        bus_ack;
  logic [15:0] bus_rdata;
  logic        clr_start = 1'b0;
  logic [8:0]  clr_base = '0;
  logic [9:0]  clr_len = '0;
  logic        clr_busy;
  logic [8:0]  s_addr_0;
  logic        s_read_0;
  logic        s_zero_0;
  logic        s_write_0;
  logic [15:0] s_din_0;
  logic [15:0] s_dout_3 = '0;
  logic        s_ready_0 = 1'b1;

  usb_ep_status_bus dut (
    .clk(clk), .rst_n(rst_n),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_we(bus_we), .bus_cyc(bus_cyc),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .clr_start(clr_start), .clr_base(clr_base), .clr_len(clr_len), .clr_busy(clr_busy),
    .s_addr_0(s_addr_0), .s_read_0(s_read_0), .s_zero_0(s_zero_0), .s_write_0(s_write_0),
    .s_din_0(s_din_0), .s_dout_3(s_dout_3), .s_ready_0(s_ready_0)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc_n = 0;
  int wr_cnt = 0;
  int busy_cnt = 0;
  int ack_cnt = 0;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  // RAM model: read accepted in cycle N shows on s_dout_3 during cycle N+3
  logic [15:0] mem [0:511];
  logic [15:0] p1 = '0;
  logic [15:0] p2 = '0;
  always @(posedge clk) begin
    if (s_ready_0 && s_write_0) begin
      mem[s_addr_0] <= s_din_0;
      wr_cnt <= wr_cnt + 1;
    end
    p1       <= (s_ready_0 && s_read_0) ? mem[s_addr_0] : 16'hDEAD;
    p2       <= p1;
    s_dout_3 <= p2;
  end

  initial forever begin
    @(negedge clk);
    if (clr_busy) busy_cnt++;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  typedef struct {
    string       name;
    bit          rd;
    logic [15:0] data;
    int          start;
    int          lat;
  } exp_t;

  exp_t sb[$];

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus_ack) begin
        ack_cnt++;
        if (sb.size() == 0) begin
          check("spurious_ack", 1, 0);
        end else begin
          e = sb.pop_front();
          check({e.name, "_lat"}, cyc_n - e.start, e.lat);
          if (e.rd) check({e.name, "_rdata"}, int'(bus_rdata), int'(e.data));
        end
      end
    end
  end

  task automatic bus_access(input string name, input logic [8:0] a, input bit we,
                            input logic [15:0] wd, input logic [15:0] exp, input int lat);
    exp_t e;
    int n;
    @(posedge clk); #1;
    e.name = name; e.rd = !we; e.data = exp; e.start = cyc_n; e.lat = lat;
    sb.push_back(e);
    bus_addr = a; bus_we = we; bus_wdata = wd; bus_cyc = 1'b1;
    n = 0;
    while (1) begin
      @(negedge clk);
      if (bus_ack) break;
      n++;
      if (n >= 2000) begin
        check({name, "_ack_timeout"}, 0, 1);
        break;
      end
    end
    bus_cyc = 1'b0;
  endtask

  task automatic do_clear(input logic [8:0] base, input logic [9:0] len);
    @(posedge clk); #1;
    clr_start = 1'b1; clr_base = base; clr_len = len;
    @(posedge clk); #1;
    clr_start = 1'b0;
  endtask

  task automatic wait_clear(input string name);
    int n;
    n = 0;
    while (clr_busy && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) check({name, "_busy_timeout"}, 1, 0);
  endtask

  task automatic check_outputs_zero(input string name);
    check({name, "_ack"},   int'(bus_ack),   0);
    check({name, "_rdata"}, int'(bus_rdata), 0);
    check({name, "_busy"},  int'(clr_busy),  0);
    check({name, "_read"},  int'(s_read_0),  0);
    check({name, "_write"}, int'(s_write_0), 0);
    check({name, "_zero"},  int'(s_zero_0),  0);
    check({name, "_addr"},  int'(s_addr_0),  0);
    check({name, "_din"},   int'(s_din_0),   0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int bc0, wc0, ac0, nz;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (4) @(posedge clk);

    bus_access("wr_012", 9'h012, 1'b1, 16'hBEEF, 16'h0000, 2);
    bus_access("rd_012", 9'h012, 1'b0, 16'h0000, 16'hBEEF, 5);

    // Ready low for the first 4 REQ cycles: accept in cycle 5, ack in cycle 9
    s_ready_0 = 1'b0;
    fork
      bus_access("stall_rd", 9'h012, 1'b0, 16'h0000, 16'hBEEF, 9);
      begin
        @(posedge clk); #1;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
          @(negedge clk);
          check("stall_read", int'(s_read_0), 1);
          check("stall_addr", int'(s_addr_0), 9'h012);
          check("stall_write", int'(s_write_0), 0);
        end
        @(posedge clk); #1 s_ready_0 = 1'b1;
      end
    join

    // Reset while waiting for read data
    @(posedge clk); #1;
    bus_addr = 9'h012; bus_we = 1'b0; bus_cyc = 1'b1;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b0;
    #1 check_outputs_zero("rst_wait");
    bus_cyc = 1'b0;
    ac0 = ack_cnt;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("rst_wait_no_ack", ack_cnt - ac0, 0);

    for (int a = 9'h1F0; a <= 9'h1FF; a++)
      bus_access("pre_hi", 9'(a), 1'b1, 16'hA5A5, 16'h0000, 2);
    for (int a = 9'h000; a <= 9'h00F; a++)
      bus_access("pre_lo", 9'(a), 1'b1, 16'hA5A5, 16'h0000, 2);

    bc0 = busy_cnt; wc0 = wr_cnt;
    do_clear(9'h1F8, 10'd16);
    wait_clear("clr16");
    check("clr16_busy_cycles", busy_cnt - bc0, 16);
    check("clr16_writes", wr_cnt - wc0, 16);
    bus_access("clr16_1f7", 9'h1F7, 1'b0, 16'h0, 16'hA5A5, 5);
    bus_access("clr16_1f8", 9'h1F8, 1'b0, 16'h0, 16'h0000, 5);
    bus_access("clr16_1ff", 9'h1FF, 1'b0, 16'h0, 16'h0000, 5);
    bus_access("clr16_000", 9'h000, 1'b0, 16'h0, 16'h0000, 5);
    bus_access("clr16_007", 9'h007, 1'b0, 16'h0, 16'h0000, 5);
    bus_access("clr16_008", 9'h008, 1'b0, 16'h0, 16'hA5A5, 5);

    // Clear of 0x020..0x023 wins; pending read of 0x021 acks in cycle 10
    bus_access("pre_021", 9'h021, 1'b1, 16'h1234, 16'h0000, 2);
    fork
      bus_access("collide_rd", 9'h021, 1'b0, 16'h0, 16'h0000, 10);
      begin
        do_clear(9'h020, 10'd4);
        wait_clear("collide");
      end
    join

    bc0 = busy_cnt; wc0 = wr_cnt;
    fork
      bus_access("len0_wr", 9'h030, 1'b1, 16'h5A5A, 16'h0000, 2);
      do_clear(9'h030, 10'd0);
    join
    repeat (4) @(negedge clk);
    check("len0_busy_cycles", busy_cnt - bc0, 0);
    check("len0_writes", wr_cnt - wc0, 1);
    bus_access("len0_rd", 9'h030, 1'b0, 16'h0, 16'h5A5A, 5);

    // Reset in the middle of a clear
    do_clear(9'h040, 10'd100);
    repeat (5) @(negedge clk);
    check("rst_clr_busy_before", int'(clr_busy), 1);
    #1 rst_n = 1'b0;
    #1 check_outputs_zero("rst_clr");
    ac0 = ack_cnt;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("rst_clr_no_ack", ack_cnt - ac0, 0);
    check("rst_clr_idle", int'(clr_busy), 0);
    bus_access("post_rst_wr", 9'h050, 1'b1, 16'h4242, 16'h0000, 2);
    bus_access("post_rst_rd", 9'h050, 1'b0, 16'h0, 16'h4242, 5);

    bus_access("pre_1ab", 9'h1AB, 1'b1, 16'h7777, 16'h0000, 2);
    bus_access("pre_0ff", 9'h0FF, 1'b1, 16'h1111, 16'h0000, 2);
    bc0 = busy_cnt; wc0 = wr_cnt;
    do_clear(9'h100, 10'd512);
    wait_clear("clr512");
    check("clr512_busy_cycles", busy_cnt - bc0, 512);
    check("clr512_writes", wr_cnt - wc0, 512);
    nz = 0;
    for (int a = 0; a < 512; a++) if (mem[a] !== 16'h0000) nz++;
    check("clr512_nonzero_words", nz, 0);
    bus_access("clr512_1ab", 9'h1AB, 1'b0, 16'h0, 16'h0000, 5);
    bus_access("clr512_0ff", 9'h0FF, 1'b0, 16'h0, 16'h0000, 5);

    repeat (4) @(negedge clk);
    check("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
